// File: rtl/serial_pattern_gen.sv
// Parallel-to-serial stimulus source: captures a switch pattern on a start press
// and shifts it out MSB first, one bit every DIV clocks, optionally repeating.
module serial_pattern_gen #(
   parameter int WIDTH = 8,
   parameter int DIV   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     repeat_en,
   input  logic [WIDTH-1:0]         data_in,
   output logic                     x_out,
   output logic                     bit_stb,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(WIDTH)-1:0] bit_idx
);

   localparam int IW = $clog2(WIDTH);
   localparam int CW = $clog2(DIV) + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic             s1_q, s2_q, s3_q;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic             x_q, x_d;
   logic             stb_q, stb_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             rise;

   assign rise = s2_q & ~s3_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
         shreg_q <= '0;
         cap_q   <= '0;
         x_q     <= 1'b0;
         stb_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         s1_q    <= start;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         shreg_q <= shreg_d;
         cap_q   <= cap_d;
         x_q     <= x_d;
         stb_q   <= stb_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cap_d   = cap_q;
      x_d     = x_q;
      stb_d   = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            x_d    = 1'b0;
            busy_d = 1'b0;
            if (rise) begin
               shreg_d = data_in;
               cap_d   = data_in;
               x_d     = data_in[WIDTH-1];
               idx_d   = '0;
               cnt_d   = '0;
               stb_d   = 1'b1;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q == CW'(DIV - 1)) begin
               cnt_d = '0;
               if (idx_q != IW'(WIDTH - 1)) begin
                  shreg_d = shreg_q << 1;
                  x_d     = shreg_q[WIDTH-2];
                  idx_d   = idx_q + 1'b1;
                  stb_d   = 1'b1;
               end else if (repeat_en) begin
                  // Reload from the captured copy so switch changes never leak in.
                  shreg_d = cap_q;
                  x_d     = cap_q[WIDTH-1];
                  idx_d   = '0;
                  stb_d   = 1'b1;
               end else begin
                  x_d     = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  idx_d   = '0;
                  state_d = DONE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            x_d     = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign x_out   = x_q;
   assign bit_stb = stb_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign bit_idx = idx_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed bench: one DIV=1 instance for most scenarios, one DIV=4 instance for prescaling.
module tb_serial_pattern_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       start1, rep1, start4, rep4;
   logic [7:0] din1, din4;
   logic       x1, stb1, busy1, done1, x4, stb4, busy4, done4;
   logic [2:0] idx1, idx4;
   logic [6:0] o1, o4;
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   serial_pattern_gen #(.WIDTH(8), .DIV(1)) u_d1 (
      .clk(clk), .rst(rst), .start(start1), .repeat_en(rep1), .data_in(din1),
      .x_out(x1), .bit_stb(stb1), .busy(busy1), .done(done1), .bit_idx(idx1));

   serial_pattern_gen #(.WIDTH(8), .DIV(4)) u_d4 (
      .clk(clk), .rst(rst), .start(start4), .repeat_en(rep4), .data_in(din4),
      .x_out(x4), .bit_stb(stb4), .busy(busy4), .done(done4), .bit_idx(idx4));

   assign o1 = {x1, stb1, busy1, done1, idx1};
   assign o4 = {x4, stb4, busy4, done4, idx4};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start pulse of one clock; returns with the MSB on x_out (edge k+2).
   task automatic press1();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      tick();
      tick();
   endtask

   // Checks 8 bits of a DIV=1 pass; returns in the cycle after bit 7.
   task automatic check_bits(input string tag, input logic [7:0] pat);
      for (int i = 0; i < 8; i++) begin
         chk(tag, o1, {pat[7-i], 1'b1, 1'b1, 1'b0, 3'(i)});
         tick();
      end
   endtask

   initial begin
      int ndone, nstb;
      rst = 1'b1; start1 = 0; rep1 = 0; start4 = 0; rep4 = 0; din1 = 0; din4 = 0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_d1", o1, 7'b0);
      chk("rst_d4", o4, 7'b0);

      // Alternating pattern, done pulse, then idle
      din1 = 8'b1010_1010;
      press1();
      check_bits("t1_bits", 8'hAA);
      chk("t1_done", o1[6:3], 4'b0001);
      tick();
      chk("t1_idle", o1[6:3], 4'b0000);

      // DIV=4: every bit held 4 clocks, strobe on the first of them
      din4 = 8'hC3;
      start4 = 1'b1; tick(); start4 = 1'b0; tick(); tick();
      for (int i = 0; i < 32; i++) begin
         logic [7:0] p;
         p = 8'hC3;
         chk("t2_bits", o4, {p[7-i/4], (i % 4) == 0, 1'b1, 1'b0, 3'(i/4)});
         tick();
      end
      chk("t2_done", o4[6:3], 4'b0001);
      tick();
      chk("t2_idle", o4[6:3], 4'b0000);

      // Repeat mode: back-to-back passes, cleared during the fourth pass
      din1 = 8'h15; rep1 = 1'b1;
      press1();
      for (int i = 0; i < 32; i++) begin
         logic [7:0] p;
         p = 8'h15;
         if (i == 26) rep1 = 1'b0;
         chk("t3_bits", o1, {p[7-(i%8)], 1'b1, 1'b1, 1'b0, 3'(i%8)});
         tick();
      end
      chk("t3_done", o1[6:3], 4'b0001);
      tick();

      // Re-press and switch change during SHIFT are ignored
      din1 = 8'hF0;
      press1();
      din1 = 8'h0F; start1 = 1'b1;
      check_bits("t4_first", 8'hF0);
      chk("t4_done", o1[6:3], 4'b0001);
      tick();
      start1 = 1'b0;
      tick(); tick(); tick();
      chk("t4_idle", o1[6:3], 4'b0000);
      press1();
      check_bits("t4_second", 8'h0F);
      tick();

      // Reset at bit 3 aborts with no done; the next pass is complete
      din1 = 8'hA5;
      press1();
      tick(); tick(); tick();
      chk("t5_at3", o1, {1'b0, 1'b1, 1'b1, 1'b0, 3'd3});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_rst", o1, 7'b0);
      ndone = 0;
      for (int i = 0; i < 6; i++) begin tick(); ndone += int'(done1); end
      chk("t5_nodone", 32'(ndone), 32'd0);
      press1();
      check_bits("t5_rerun", 8'hA5);
      chk("t5_done", o1[6:3], 4'b0001);
      tick();

      // Held start gives one pass; a single-clock glitch gives one pass
      din1 = 8'h81; start1 = 1'b1;
      ndone = 0; nstb = 0;
      for (int i = 0; i < 100; i++) begin
         tick(); ndone += int'(done1); nstb += int'(stb1);
      end
      chk("t6_hold_done", 32'(ndone), 32'd1);
      chk("t6_hold_stb", 32'(nstb), 32'd8);
      start1 = 1'b0;
      tick(); tick(); tick();
      start1 = 1'b1; tick(); start1 = 1'b0;
      ndone = 0; nstb = 0;
      for (int i = 0; i < 20; i++) begin
         tick(); ndone += int'(done1); nstb += int'(stb1);
      end
      chk("t6_glitch_done", 32'(ndone), 32'd1);
      chk("t6_glitch_stb", 32'(nstb), 32'd8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
